// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: opcode map, step encoding,
// instruction classes and the registered control-word layout.
package control_sequencer_pkg;

    localparam int unsigned OPW          = 5;
    localparam int unsigned STEP_W       = 3;
    localparam int unsigned MEM_WAIT_DEF = 15;

    // Step encoding; HALT takes the last code so the 3-bit register is dense.
    localparam logic [STEP_W-1:0] STEP_T0   = 3'd0;
    localparam logic [STEP_W-1:0] STEP_T1   = 3'd1;
    localparam logic [STEP_W-1:0] STEP_T2   = 3'd2;
    localparam logic [STEP_W-1:0] STEP_T3   = 3'd3;
    localparam logic [STEP_W-1:0] STEP_T4   = 3'd4;
    localparam logic [STEP_W-1:0] STEP_T5   = 3'd5;
    localparam logic [STEP_W-1:0] STEP_T6   = 3'd6;
    localparam logic [STEP_W-1:0] STEP_HALT = 3'd7;

    localparam logic [OPW-1:0] OPC_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OPC_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OPC_AND  = 5'b00101;
    localparam logic [OPW-1:0] OPC_OR   = 5'b00110;
    localparam logic [OPW-1:0] OPC_ROR  = 5'b00111;
    localparam logic [OPW-1:0] OPC_ROL  = 5'b01000;
    localparam logic [OPW-1:0] OPC_SHR  = 5'b01001;
    localparam logic [OPW-1:0] OPC_SHRA = 5'b01010;
    localparam logic [OPW-1:0] OPC_SHL  = 5'b01011;
    localparam logic [OPW-1:0] OPC_DIV  = 5'b01111;
    localparam logic [OPW-1:0] OPC_MUL  = 5'b10000;
    localparam logic [OPW-1:0] OPC_NEG  = 5'b10001;
    localparam logic [OPW-1:0] OPC_NOT  = 5'b10010;
    localparam logic [OPW-1:0] OPC_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OPC_HALT = 5'b11011;

    typedef enum logic [2:0] {
        CLS_RFMT,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_NOP,
        CLS_HALT,
        CLS_ILL
    } instr_class_t;

    // One registered control word driven onto the Datapath each step.
    typedef struct packed {
        logic           pc_out;
        logic           zlow_out;
        logic           zhigh_out;
        logic           mdr_out;
        logic           mar_in;
        logic           z_in;
        logic           pc_in;
        logic           mdr_in;
        logic           ir_in;
        logic           y_in;
        logic           hi_in;
        logic           lo_in;
        logic           inc_pc;
        logic           read;
        logic           gra;
        logic           grb;
        logic           grc;
        logic           r_in;
        logic           r_out;
        logic [OPW-1:0] alu_op;
        logic           illegal;
        logic           run;
    } ctrl_t;

    // Control word held while in reset: everything idle, still running.
    function automatic ctrl_t ctrl_reset();
        ctrl_t c;
        c     = '0;
        c.run = 1'b1;
        return c;
    endfunction

    // Final execute step of each class; Stop is only honoured there.
    function automatic logic [STEP_W-1:0] last_step(input instr_class_t cls);
        case (cls)
            CLS_RFMT:   return STEP_T5;
            CLS_MULDIV: return STEP_T6;
            CLS_UNARY:  return STEP_T4;
            default:    return STEP_T3;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_instr_class_decode.sv
// Combinational opcode classifier.
//   opc    in  OPW  latched or incoming opcode
//   cls_c  out      instruction class (CLS_ILL for anything undecodable)
module control_sequencer_instr_class_decode
    import control_sequencer_pkg::*;
(
    input  logic [OPW-1:0] opc,
    output instr_class_t   cls_c
);

    always_comb begin
        cls_c = CLS_ILL;
        case (opc)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ROR,
            OPC_ROL, OPC_SHR, OPC_SHRA, OPC_SHL:  cls_c = CLS_RFMT;
            OPC_MUL, OPC_DIV:                     cls_c = CLS_MULDIV;
            OPC_NEG, OPC_NOT:                     cls_c = CLS_UNARY;
            OPC_NOP:                              cls_c = CLS_NOP;
            OPC_HALT:                             cls_c = CLS_HALT;
            default:                              cls_c = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus Datapath: fetch T0-T2, execute
// T3-T6, HALT. Every output is a flop loaded with the decode of the next step,
// so strobes are stable for the whole step and drop at once on Reset_n.
// The first cycle after reset release is an idle T0 with no strobes.
//   Clock, Reset_n          clock / async active-low reset
//   IR                      instruction register (opcode IR[31:27])
//   Mem_ready               memory read data valid
//   Stop                    halt request at the next instruction boundary
//   Run                     1 while sequencing
//   PCout..MDRout           bus drivers
//   MARin..HIin/LOin        register loads
//   IncPC, Read             ALU +4 select, memory read
//   Gra, Grb, Grc, Rin, Rout GP register select/strobe
//   Alu_op                  ALU operation code
//   Illegal                 one-cycle fault pulse
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = MEM_WAIT_DEF
) (
    input  logic           Clock,
    input  logic           Reset_n,
    input  logic [31:0]    IR,
    input  logic           Mem_ready,
    input  logic           Stop,
    output logic           Run,
    output logic           PCout,
    output logic           Zlowout,
    output logic           Zhighout,
    output logic           MDRout,
    output logic           MARin,
    output logic           Zin,
    output logic           PCin,
    output logic           MDRin,
    output logic           IRin,
    output logic           Yin,
    output logic           HIin,
    output logic           LOin,
    output logic           IncPC,
    output logic           Read,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           Rout,
    output logic [OPW-1:0] Alu_op,
    output logic           Illegal
);

    localparam int unsigned WAIT_W = $clog2(MEM_WAIT_MAX + 1);

    logic [STEP_W-1:0] step_q, step_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [OPW-1:0]    opc_q, opc_d;
    logic              launched_q;
    ctrl_t             ctl_q, ctl_d;
    logic [OPW-1:0]    ir_opc_c;
    logic [OPW-1:0]    opc_sel_c;
    instr_class_t      cls_c;
    logic              unused_ir_c;

    assign ir_opc_c    = IR[31:27];
    assign unused_ir_c = ^IR[26:0];

    // In T2 the next step (T3) is decoded from the incoming IR; later steps use the latch.
    assign opc_sel_c = (step_q == STEP_T2) ? ir_opc_c : opc_q;

    control_sequencer_instr_class_decode u_decode (
        .opc   (opc_sel_c),
        .cls_c (cls_c)
    );

    // State, wait counter, opcode latch and registered control word.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            step_q     <= STEP_T0;
            cnt_q      <= '0;
            opc_q      <= '0;
            launched_q <= 1'b0;
            ctl_q      <= ctrl_reset();
        end else begin
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            opc_q      <= opc_d;
            launched_q <= 1'b1;
            ctl_q      <= ctl_d;
        end
    end

    // Next step and the control word that step will drive.
    always_comb begin
        step_d    = step_q;
        cnt_d     = cnt_q;
        opc_d     = opc_q;
        ctl_d     = '0;
        ctl_d.run = 1'b1;

        if (!launched_q) begin
            step_d = STEP_T0;
        end else begin
            case (step_q)
                STEP_T0: step_d = STEP_T1;
                STEP_T1: begin
                    if (Mem_ready) begin
                        step_d = STEP_T2;
                        cnt_d  = '0;
                    end else if (cnt_q == WAIT_W'(MEM_WAIT_MAX - 1)) begin
                        step_d        = STEP_HALT;
                        cnt_d         = '0;
                        ctl_d.illegal = 1'b1;
                    end else begin
                        cnt_d = cnt_q + WAIT_W'(1);
                    end
                end
                STEP_T2: begin
                    step_d = STEP_T3;
                    opc_d  = ir_opc_c;
                end
                STEP_HALT: step_d = STEP_HALT;
                default: begin
                    if (step_q == last_step(cls_c)) begin
                        step_d = (Stop || (cls_c == CLS_HALT)) ? STEP_HALT : STEP_T0;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            endcase
        end

        case (step_d)
            STEP_T0: begin
                ctl_d.pc_out = 1'b1;
                ctl_d.mar_in = 1'b1;
                ctl_d.inc_pc = 1'b1;
                ctl_d.z_in   = 1'b1;
            end
            STEP_T1: begin
                ctl_d.zlow_out = 1'b1;
                ctl_d.read     = 1'b1;
                ctl_d.mdr_in   = 1'b1;
                // PC loads only on the T0->T1 edge, never on wait-state re-entries.
                ctl_d.pc_in    = launched_q && (step_q == STEP_T0);
            end
            STEP_T2: begin
                ctl_d.mdr_out = 1'b1;
                ctl_d.ir_in   = 1'b1;
            end
            STEP_T3: begin
                case (cls_c)
                    CLS_RFMT: begin
                        ctl_d.grb   = 1'b1;
                        ctl_d.r_out = 1'b1;
                        ctl_d.y_in  = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ctl_d.gra   = 1'b1;
                        ctl_d.r_out = 1'b1;
                        ctl_d.y_in  = 1'b1;
                    end
                    CLS_UNARY: begin
                        ctl_d.grb    = 1'b1;
                        ctl_d.r_out  = 1'b1;
                        ctl_d.alu_op = opc_sel_c;
                        ctl_d.z_in   = 1'b1;
                    end
                    CLS_ILL: ctl_d.illegal = 1'b1;
                    default: ;
                endcase
            end
            STEP_T4: begin
                case (cls_c)
                    CLS_RFMT: begin
                        ctl_d.grc    = 1'b1;
                        ctl_d.r_out  = 1'b1;
                        ctl_d.alu_op = opc_sel_c;
                        ctl_d.z_in   = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ctl_d.grb    = 1'b1;
                        ctl_d.r_out  = 1'b1;
                        ctl_d.alu_op = opc_sel_c;
                        ctl_d.z_in   = 1'b1;
                    end
                    CLS_UNARY: begin
                        ctl_d.zlow_out = 1'b1;
                        ctl_d.gra      = 1'b1;
                        ctl_d.r_in     = 1'b1;
                    end
                    default: ;
                endcase
            end
            STEP_T5: begin
                case (cls_c)
                    CLS_RFMT: begin
                        ctl_d.zlow_out = 1'b1;
                        ctl_d.gra      = 1'b1;
                        ctl_d.r_in     = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ctl_d.zlow_out = 1'b1;
                        ctl_d.lo_in    = 1'b1;
                    end
                    default: ;
                endcase
            end
            STEP_T6: begin
                ctl_d.zhigh_out = 1'b1;
                ctl_d.hi_in     = 1'b1;
            end
            STEP_HALT: ctl_d.run = 1'b0;
            default: ;
        endcase
    end

    assign Run      = ctl_q.run;
    assign PCout    = ctl_q.pc_out;
    assign Zlowout  = ctl_q.zlow_out;
    assign Zhighout = ctl_q.zhigh_out;
    assign MDRout   = ctl_q.mdr_out;
    assign MARin    = ctl_q.mar_in;
    assign Zin      = ctl_q.z_in;
    assign PCin     = ctl_q.pc_in;
    assign MDRin    = ctl_q.mdr_in;
    assign IRin     = ctl_q.ir_in;
    assign Yin      = ctl_q.y_in;
    assign HIin     = ctl_q.hi_in;
    assign LOin     = ctl_q.lo_in;
    assign IncPC    = ctl_q.inc_pc;
    assign Read     = ctl_q.read;
    assign Gra      = ctl_q.gra;
    assign Grb      = ctl_q.grb;
    assign Grc      = ctl_q.grc;
    assign Rin      = ctl_q.r_in;
    assign Rout     = ctl_q.r_out;
    assign Alu_op   = ctl_q.alu_op;
    assign Illegal  = ctl_q.illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer. A per-instruction planner builds the
// expected step-by-step control vectors and input schedule into queues; the
// runner replays the inputs and compares outputs on every falling edge.
module tb_control_sequencer;

    localparam int unsigned WAIT_MAX = 15;

    // Bit positions of the packed observation vector.
    localparam logic [31:0] M_PCOUT  = 32'd1 << 0;
    localparam logic [31:0] M_ZLOW   = 32'd1 << 1;
    localparam logic [31:0] M_ZHIGH  = 32'd1 << 2;
    localparam logic [31:0] M_MDROUT = 32'd1 << 3;
    localparam logic [31:0] M_MARIN  = 32'd1 << 4;
    localparam logic [31:0] M_ZIN    = 32'd1 << 5;
    localparam logic [31:0] M_PCIN   = 32'd1 << 6;
    localparam logic [31:0] M_MDRIN  = 32'd1 << 7;
    localparam logic [31:0] M_IRIN   = 32'd1 << 8;
    localparam logic [31:0] M_YIN    = 32'd1 << 9;
    localparam logic [31:0] M_HIIN   = 32'd1 << 10;
    localparam logic [31:0] M_LOIN   = 32'd1 << 11;
    localparam logic [31:0] M_INCPC  = 32'd1 << 12;
    localparam logic [31:0] M_READ   = 32'd1 << 13;
    localparam logic [31:0] M_GRA    = 32'd1 << 14;
    localparam logic [31:0] M_GRB    = 32'd1 << 15;
    localparam logic [31:0] M_GRC    = 32'd1 << 16;
    localparam logic [31:0] M_RIN    = 32'd1 << 17;
    localparam logic [31:0] M_ROUT   = 32'd1 << 18;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic [31:0] IR = '0;
    logic        Mem_ready = 1'b0;
    logic        Stop = 1'b0;
    logic        Run, PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin;
    logic        IRin, Yin, HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, Illegal;
    logic [4:0]  Alu_op;

    int n_err = 0;
    int n_chk = 0;

    logic [31:0] exp_q[$];
    logic [31:0] ir_q[$];
    logic        mr_q[$];
    logic        st_q[$];
    string       tag_q[$];

    control_sequencer dut (
        .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .Mem_ready(Mem_ready), .Stop(Stop),
        .Run(Run), .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .Rin(Rin), .Rout(Rout), .Alu_op(Alu_op), .Illegal(Illegal)
    );

    always #5 Clock = ~Clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] got_vec();
        return {6'd0, Run, Illegal, Alu_op, Rout, Rin, Grc, Grb, Gra, Read, IncPC,
                LOin, HIin, Yin, IRin, MDRin, PCin, Zin, MARin, MDRout, Zhighout,
                Zlowout, PCout};
    endfunction

    function automatic logic [31:0] mk(input logic [31:0] mask, input logic [4:0] alu,
                                       input logic ill, input logic run);
        return mask | ({27'd0, alu} << 19) | ({31'd0, ill} << 24) | ({31'd0, run} << 25);
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    task automatic push(input string tag, input logic [31:0] exp, input logic mr,
                        input logic st, input logic [31:0] ir);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
        mr_q.push_back(mr);
        st_q.push_back(st);
        ir_q.push_back(ir);
    endtask

    // Expected behaviour of one instruction: fetch with `waits` low Mem_ready
    // cycles (>= WAIT_MAX means memory never answers), then the execute steps.
    task automatic plan_instr(input logic [31:0] instr, input int waits, input bit stop,
                              output bit halted);
        logic [4:0]  opc;
        logic [31:0] ex[4];
        int          n;
        bit          is_halt;
        opc     = instr[31:27];
        is_halt = 1'b0;
        halted  = 1'b0;
        push("T0", mk(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0, 1'b0, 1'b1), rbit(), rbit(), instr);
        if (waits >= int'(WAIT_MAX)) begin
            for (int j = 0; j < int'(WAIT_MAX); j++)
                push("T1_wait", mk(M_ZLOW | M_READ | M_MDRIN | ((j == 0) ? M_PCIN : 32'd0),
                                   5'd0, 1'b0, 1'b1), 1'b0, rbit(), instr);
            push("timeout", mk(32'd0, 5'd0, 1'b1, 1'b0), rbit(), rbit(), $urandom);
            halted = 1'b1;
            return;
        end
        for (int j = 0; j <= waits; j++)
            push("T1", mk(M_ZLOW | M_READ | M_MDRIN | ((j == 0) ? M_PCIN : 32'd0),
                          5'd0, 1'b0, 1'b1), (j == waits), rbit(), instr);
        push("T2", mk(M_MDROUT | M_IRIN, 5'd0, 1'b0, 1'b1), rbit(), rbit(), instr);
        case (opc)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: begin
                n = 3;
                ex[0] = mk(M_GRB | M_ROUT | M_YIN, 5'd0, 1'b0, 1'b1);
                ex[1] = mk(M_GRC | M_ROUT | M_ZIN, opc, 1'b0, 1'b1);
                ex[2] = mk(M_ZLOW | M_GRA | M_RIN, 5'd0, 1'b0, 1'b1);
            end
            5'b10000, 5'b01111: begin
                n = 4;
                ex[0] = mk(M_GRA | M_ROUT | M_YIN, 5'd0, 1'b0, 1'b1);
                ex[1] = mk(M_GRB | M_ROUT | M_ZIN, opc, 1'b0, 1'b1);
                ex[2] = mk(M_ZLOW | M_LOIN, 5'd0, 1'b0, 1'b1);
                ex[3] = mk(M_ZHIGH | M_HIIN, 5'd0, 1'b0, 1'b1);
            end
            5'b10001, 5'b10010: begin
                n = 2;
                ex[0] = mk(M_GRB | M_ROUT | M_ZIN, opc, 1'b0, 1'b1);
                ex[1] = mk(M_ZLOW | M_GRA | M_RIN, 5'd0, 1'b0, 1'b1);
            end
            5'b11010: begin
                n = 1;
                ex[0] = mk(32'd0, 5'd0, 1'b0, 1'b1);
            end
            5'b11011: begin
                n = 1;
                is_halt = 1'b1;
                ex[0] = mk(32'd0, 5'd0, 1'b0, 1'b1);
            end
            default: begin
                n = 1;
                ex[0] = mk(32'd0, 5'd0, 1'b1, 1'b1);
            end
        endcase
        for (int k = 0; k < n; k++)
            push($sformatf("T%0d", k + 3), ex[k], rbit(),
                 (stop && k >= n - 2) ? 1'b1 : ((k == n - 1) ? 1'b0 : rbit()), $urandom);
        halted = stop || is_halt;
    endtask

    task automatic push_halt(input int cycles);
        for (int j = 0; j < cycles; j++)
            push("HALT", mk(32'd0, 5'd0, 1'b0, 1'b0), rbit(), rbit(), $urandom);
    endtask

    // Replays planned cycles; called and returning on a falling edge.
    task automatic drain(input int max_cycles);
        int n = 0;
        while (exp_q.size() > 0 && n < max_cycles) begin
            check(tag_q.pop_front(), got_vec(), exp_q.pop_front());
            check("bus_onehot", 32'($onehot0({PCout, Zlowout, Zhighout, MDRout, Rout})), 32'd1);
            check("rin_rout", {31'd0, Rin & Rout}, 32'd0);
            Mem_ready = mr_q.pop_front();
            Stop      = st_q.pop_front();
            IR        = ir_q.pop_front();
            @(negedge Clock);
            n++;
        end
    endtask

    // Asynchronous reset mid-cycle; outputs must settle before any clock edge.
    task automatic do_reset();
        #2;
        Reset_n = 1'b0;
        #1;
        check("reset", got_vec(), mk(32'd0, 5'd0, 1'b0, 1'b1));
        exp_q.delete(); tag_q.delete(); mr_q.delete(); st_q.delete(); ir_q.delete();
        @(negedge Clock);
        Reset_n = 1'b1;
        push("idle", mk(32'd0, 5'd0, 1'b0, 1'b1), rbit(), rbit(), $urandom);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] legal[15];
        legal = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
                  5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b10001, 5'b10010, 5'b11010,
                  5'b11011};
        if ($urandom_range(0, 4) == 0) return $urandom;
        return {legal[$urandom_range(0, 14)], 27'($urandom)};
    endfunction

    initial begin
        bit h;
        @(negedge Clock);

        // Directed fetch/execute sequences, wait states and a Stop-driven halt.
        do_reset();
        plan_instr(32'h28918000, 0, 1'b0, h);
        plan_instr({5'b10000, 27'h0118000}, 0, 1'b0, h);
        plan_instr({5'b00011, 27'($urandom)}, 3, 1'b0, h);
        plan_instr({5'b11111, 27'($urandom)}, 1, 1'b0, h);
        plan_instr({5'b10001, 27'($urandom)}, 0, 1'b0, h);
        plan_instr({5'b10010, 27'($urandom)}, 2, 1'b0, h);
        plan_instr({5'b01111, 27'($urandom)}, 0, 1'b0, h);
        plan_instr({5'b00111, 27'($urandom)}, int'(WAIT_MAX) - 1, 1'b0, h);
        plan_instr({5'b00011, 27'($urandom)}, 0, 1'b1, h);
        push_halt(3);
        drain(1000);

        // nop then halt opcode.
        do_reset();
        plan_instr({5'b11010, 27'($urandom)}, 0, 1'b0, h);
        plan_instr({5'b01011, 27'($urandom)}, 1, 1'b0, h);
        plan_instr({5'b11011, 27'($urandom)}, 0, 1'b0, h);
        push_halt(3);
        drain(1000);

        // Memory never answers.
        do_reset();
        plan_instr({5'b00011, 27'($urandom)}, 99, 1'b0, h);
        push_halt(2);
        drain(1000);

        // Reset asserted while an add sits in T4.
        do_reset();
        plan_instr({5'b00011, 27'($urandom)}, 0, 1'b0, h);
        drain(5);
        check("pre_reset_T4", got_vec(), exp_q[0]);
        do_reset();
        plan_instr({5'b00100, 27'($urandom)}, 1, 1'b0, h);
        drain(1000);

        // Random programs.
        for (int seg = 0; seg < 10; seg++) begin
            do_reset();
            h = 1'b0;
            for (int i = 0; i < 12 && !h; i++)
                plan_instr(rand_instr(),
                           ($urandom_range(0, 19) == 0) ? int'(WAIT_MAX) : int'($urandom_range(0, 4)),
                           ($urandom_range(0, 11) == 0), h);
            if (h) push_halt(3);
            drain(2000);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
